layer5_argmax_ctrl: RTL and testbench
=====================================

LAYER5_ARGMAX_CTRL -- requirements
Module: layer5_argmax_ctrl

Interface
REQ-001 Parameter N_IMG, default 10000, number of images per run; all_done_o fires on the last one.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  one-cycle pulse from the layer-4 done_o; the layer-4 output buffer is valid.
REQ-005 x_en_o / x_addr_o  output  1 / 6  read strobe and address into the layer-4 output buffer (64 entries).
REQ-006 x_data_i  input  8  signed activation, valid 1 cycle after x_en_o.
REQ-007 w_en_o / w_addr_o  output  1 / 10  read strobe and address into the layer-5 weight ROM (640 entries).
REQ-008 w_data_i  input  8  signed weight, valid 1 cycle after w_en_o.
REQ-009 busy_o  output  1  high from the cycle after start acceptance until the cycle valid_o is high, inclusive.
REQ-010 valid_o  output  1  one-cycle pulse; class_o and score_o are valid.
REQ-011 class_o  output  4  predicted digit 0..9, held until the next valid_o.
REQ-012 score_o  output  24  signed winning accumulator value, held with class_o.
REQ-013 img_cnt_o  output  14  images completed since reset.
REQ-014 all_done_o  output  1  one-cycle pulse, coincident with valid_o, when img_cnt_o reaches N_IMG.

Function
REQ-015 States SHALL be IDLE, RUN, DRAIN, CMP and OUT; encoding is free.
REQ-016 IDLE->RUN on start_i; start_i in any other state SHALL be ignored.
REQ-017 RUN lasts exactly 64 cycles per class k (0..9); in cycle n it asserts x_en_o/w_en_o with x_addr_o=n and w_addr_o=k*64+n.
REQ-018 Product x_data_i*w_data_i (16-bit signed) is sign-extended and accumulated into a 24-bit signed accumulator 1 cycle after each strobe; the accumulator clears on the first product of each class; no saturation (64-term range fits).
REQ-019 RUN->DRAIN after n=63; DRAIN (1 cycle) absorbs the last product with strobes low.
REQ-020 In CMP (1 cycle), best := acc and best_idx := k when k==0 or acc > best (strict signed); ties keep the lower index.
REQ-021 CMP->RUN with k+1 when k<9; CMP->OUT when k==9.
REQ-022 OUT (1 cycle) registers class_o/score_o from best, pulses valid_o, increments img_cnt_o, then returns to IDLE.
REQ-023 Latency: the edge sampling start_i is edge 0; class k CMP occurs at edge 66(k+1); valid_o is high in the cycle after edge 661.
REQ-024 When img_cnt_o becomes N_IMG, all_done_o pulses and img_cnt_o wraps to 0.
REQ-025 x_en_o and w_en_o SHALL be low in every state except RUN.

Reset
REQ-026 Asynchronous reset SHALL force IDLE, k=0, the accumulator, best and img_cnt_o to 0, and every output to 0.
REQ-027 Reset mid-image SHALL abandon the image without a valid_o pulse; the next start_i begins a fresh image.

Structure
REQ-028 Package layer5_pkg SHALL hold the state type, N_IN=64, N_CLS=10, DATA_W=8 and ACC_W=24.
REQ-029 One sub-module mac_acc (signed 8x8 multiply, 24-bit accumulate, synchronous clear-on-first input) SHALL hold the datapath.

Verification
REQ-030 All x=1 and weights of class k all set to k-5 -> class_o=9, score_o=256, valid_o at the cycle after edge 661.
REQ-031 All x=-1 and weights of class k all set to k-5 -> class_o=0, score_o=320 (signed compare check).
REQ-032 All weights equal -> class_o=0 (tie keeps the lowest index).
REQ-033 x=127 and w=127 for class 3, all other weights 0 -> score_o=1032256, no overflow, class_o=3.
REQ-034 start_i pulsed again at edge 100 -> ignored, exactly one valid_o; rstn_i low at edge 300 -> no valid_o, all outputs 0, and a following start_i completes normally.
REQ-035 N_IMG=3 and three images -> all_done_o on the third valid_o only, img_cnt_o wraps to 0.

Source files
------------

// File: rtl/layer5_argmax_ctrl_pkg.sv
// Shared types and sizing for the layer-5 argmax controller and its MAC datapath.
package layer5_pkg;

  localparam int N_IN   = 64;
  localparam int N_CLS  = 10;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int PROD_W = 2 * DATA_W;
  localparam int X_AW   = 6;
  localparam int W_AW   = 10;
  localparam int CLS_W  = 4;
  localparam int CNT_W  = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CMP   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/layer5_argmax_ctrl_if.sv
// Read ports into the layer-4 activation buffer and the layer-5 weight ROM.
// Both memories return data one cycle after the strobe; there is no backpressure.
interface layer5_argmax_ctrl_if;
  import layer5_pkg::*;

  logic                     x_en;
  logic [X_AW-1:0]          x_addr;
  logic signed [DATA_W-1:0] x_data;
  logic                     w_en;
  logic [W_AW-1:0]          w_addr;
  logic signed [DATA_W-1:0] w_data;

  modport master (
    output x_en, x_addr, w_en, w_addr,
    input  x_data, w_data
  );

  modport slave (
    input  x_en, x_addr, w_en, w_addr,
    output x_data, w_data
  );
endinterface

// File: rtl/layer5_argmax_ctrl_mac_acc.sv
// Signed 8x8 multiply feeding a 24-bit accumulator; 'first' restarts the sum
// with the current product instead of adding to the previous class's total.
module mac_acc
  import layer5_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     en,
  input  logic                     first,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc <= '0;
    end else if (en) begin
      acc <= first ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/layer5_argmax_ctrl.sv
// Layer-5 controller: computes 10 dot products of 64 terms each and reports
// the index and value of the largest (lowest index wins ties).
module layer5_argmax_ctrl
  import layer5_pkg::*;
#(
  parameter int N_IMG = 10000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  // start_i is a single-cycle pulse with no ready: it is taken only in IDLE and
  // silently dropped otherwise; valid_o is a single-cycle pulse with no ready.
  input  logic                    start_i,
  layer5_argmax_ctrl_if.master    mem,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [CLS_W-1:0]        class_o,
  output logic signed [ACC_W-1:0] score_o,
  output logic [CNT_W-1:0]        img_cnt_o,
  output logic                    all_done_o,
  output state_t                  dbg_state
);

  state_t                  state;
  logic [CLS_W-1:0]        k;
  logic [X_AW-1:0]         n;
  logic                    prod_vld;
  logic                    prod_first;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] best;
  logic [CLS_W-1:0]        best_idx;

  assign dbg_state = state;

  mac_acc u_mac (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en     (prod_vld),
    .first  (prod_first),
    .a      (mem.x_data),
    .b      (mem.w_data),
    .acc    (acc)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      k          <= '0;
      n          <= '0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      best       <= '0;
      best_idx   <= '0;
      mem.x_en   <= 1'b0;
      mem.x_addr <= '0;
      mem.w_en   <= 1'b0;
      mem.w_addr <= '0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      class_o    <= '0;
      score_o    <= '0;
      img_cnt_o  <= '0;
      all_done_o <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      all_done_o <= 1'b0;
      // Memory data lands one cycle after the strobe, so the MAC enable trails it.
      prod_vld   <= mem.x_en;
      prod_first <= mem.x_en && (mem.x_addr == '0);

      case (state)
        ST_IDLE: begin
          busy_o <= start_i;
          if (start_i) begin
            state      <= ST_RUN;
            k          <= '0;
            n          <= '0;
            mem.x_en   <= 1'b1;
            mem.x_addr <= '0;
            mem.w_en   <= 1'b1;
            mem.w_addr <= '0;
          end
        end

        ST_RUN: begin
          if (n == X_AW'(N_IN - 1)) begin
            state    <= ST_DRAIN;
            mem.x_en <= 1'b0;
            mem.w_en <= 1'b0;
          end else begin
            n          <= n + 6'd1;
            mem.x_addr <= n + 6'd1;
            mem.w_addr <= {k, n + 6'd1};
          end
        end

        ST_DRAIN: state <= ST_CMP;

        ST_CMP: begin
          if (k == '0 || acc > best) begin
            best     <= acc;
            best_idx <= k;
          end
          if (k == CLS_W'(N_CLS - 1)) begin
            state <= ST_OUT;
          end else begin
            state      <= ST_RUN;
            k          <= k + 4'd1;
            n          <= '0;
            mem.x_en   <= 1'b1;
            mem.x_addr <= '0;
            mem.w_en   <= 1'b1;
            mem.w_addr <= {k + 4'd1, 6'd0};
          end
        end

        ST_OUT: begin
          // busy_o stays high through the valid_o cycle and drops in IDLE.
          state   <= ST_IDLE;
          k       <= '0;
          class_o <= best_idx;
          score_o <= best;
          valid_o <= 1'b1;
          if (({18'd0, img_cnt_o} + 32'd1) == 32'(N_IMG)) begin
            img_cnt_o  <= '0;
            all_done_o <= 1'b1;
          end else begin
            img_cnt_o <= img_cnt_o + 14'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer5_argmax_ctrl.sv
// Directed bench for layer5_argmax_ctrl with behavioural activation/weight memories.
module tb_layer5_argmax_ctrl;
  import layer5_pkg::*;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    start = 1'b0;
  logic                    busy;
  logic                    valid;
  logic [3:0]              cls;
  logic signed [23:0]      score;
  logic [13:0]             img_cnt;
  logic                    all_done;
  state_t                  dbg_state;

  logic signed [7:0] x_mem [64];
  logic signed [7:0] w_mem [640];

  int total = 0;
  int bad = 0;
  int strobe_idx = 0;
  int addr_err = 0;
  int exp_cnt = 0;

  layer5_argmax_ctrl_if mif ();

  layer5_argmax_ctrl #(.N_IMG(3)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .mem        (mif.master),
    .busy_o     (busy),
    .valid_o    (valid),
    .class_o    (cls),
    .score_o    (score),
    .img_cnt_o  (img_cnt),
    .all_done_o (all_done),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // memories with one-cycle read latency, plus a strobe-sequence monitor
  always @(posedge clk) begin
    if (mif.x_en) mif.x_data <= x_mem[mif.x_addr];
    if (mif.w_en) mif.w_data <= w_mem[mif.w_addr];
    if (!rstn || (start && !busy)) begin
      strobe_idx = 0;
    end else if (mif.x_en || mif.w_en) begin
      if (!(mif.x_en && mif.w_en) || mif.x_addr != strobe_idx[5:0] ||
          mif.w_addr != strobe_idx[9:0])
        addr_err++;
      strobe_idx++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic load_x(input int v);
    for (int i = 0; i < 64; i++) x_mem[i] = 8'(v);
  endtask

  task automatic load_w(input int c, input int v);
    for (int i = 0; i < 64; i++) w_mem[c*64 + i] = 8'(v);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  // One full image; extra_edge > 0 re-pulses start so that edge samples it.
  task automatic do_image(input string tag, input int exp_cls, input int exp_score,
                          input int extra_edge);
    int lat = 0;
    bit got = 1'b0;
    int base_err;
    base_err = addr_err;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    chk({tag, ".busy_first"}, busy, 1);
    while (lat < 2000) begin
      if (valid) begin
        got = 1'b1;
        break;
      end
      start = (extra_edge > 0 && lat == extra_edge - 1);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    exp_cnt = (exp_cnt + 1) % 3;
    chk({tag, ".got_valid"}, got, 1);
    chk({tag, ".latency"}, lat, 661);
    chk({tag, ".class"}, cls, exp_cls);
    chk({tag, ".score"}, 32'(score), exp_score);
    chk({tag, ".img_cnt"}, img_cnt, exp_cnt);
    chk({tag, ".all_done"}, all_done, exp_cnt == 0);
    chk({tag, ".busy_at_valid"}, busy, 1);
    chk({tag, ".strobes"}, strobe_idx, 640);
    chk({tag, ".addr_seq"}, addr_err, base_err);
    @(negedge clk);
    chk({tag, ".valid_drop"}, valid, 0);
    chk({tag, ".busy_drop"}, busy, 0);
    chk({tag, ".done_drop"}, all_done, 0);
    chk({tag, ".class_hold"}, cls, exp_cls);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".valid"}, valid, 0);
    chk({tag, ".class"}, cls, 0);
    chk({tag, ".score"}, 32'(score), 0);
    chk({tag, ".img_cnt"}, img_cnt, 0);
    chk({tag, ".all_done"}, all_done, 0);
    chk({tag, ".x_en"}, mif.x_en, 0);
    chk({tag, ".w_en"}, mif.w_en, 0);
    chk({tag, ".x_addr"}, mif.x_addr, 0);
    chk({tag, ".w_addr"}, mif.w_addr, 0);
    chk({tag, ".state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    // reset
    #2;
    chk_zero("rst");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");

    // x=1, class k weights k-5: scores 64*(k-5), class 9 wins with 256
    load_x(1);
    for (int c = 0; c < 10; c++) load_w(c, c - 5);
    do_image("pos", 9, 256, 0);

    // x=-1: scores -64*(k-5), class 0 wins with 320
    load_x(-1);
    do_image("neg", 0, 320, 0);

    // all weights equal: every class scores 2*3*64=384, lowest index kept
    load_x(2);
    for (int c = 0; c < 10; c++) load_w(c, 3);
    do_image("tie", 0, 384, 0);

    // 127*127*64 = 1032256 on class 3 only
    load_x(127);
    for (int c = 0; c < 10; c++) load_w(c, (c == 3) ? 127 : 0);
    do_image("max", 3, 1032256, 0);

    // all other classes negative, class 7 at zero; second start at edge 100 ignored
    load_x(1);
    for (int c = 0; c < 10; c++) load_w(c, (c == 7) ? 0 : -(c + 1));
    do_image("restart", 7, 0, 100);
    quiet("restart.no_second_valid", 700);

    // reset asserted at edge 300 of an image
    load_x(1);
    for (int c = 0; c < 10; c++) load_w(c, c - 5);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (299) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk); rstn = 1'b1;
    exp_cnt = 0;
    quiet("midrst.no_valid", 800);

    // fresh image after the abandoned one
    do_image("after_rst", 9, 256, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
